// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: drains a FIFO read port into a valid/ready stream through a 2-entry skid buffer
//   rclk/rrst         clock, synchronous active-high reset
//   rdata/rempty/rinc FIFO read port (head word, empty flag, pop strobe)
//   halt              stop popping, buffered words still drain
//   flush             discard buffered words, no pop that cycle
//   m_valid/m_data/m_ready  output stream
//   occ               skid occupancy 0..2
//   pop_cnt           popped-word counter, present only with FRS_CNT_EN defined
module fifo_rd_stream #(
  parameter int DSIZE = 8,
  parameter int CSIZE = 16
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic [DSIZE-1:0] rdata,
  input  logic             rempty,
  output logic             rinc,
  input  logic             halt,
  input  logic             flush,
  output logic             m_valid,
  output logic [DSIZE-1:0] m_data,
  input  logic             m_ready,
  output logic [1:0]       occ
`ifdef FRS_CNT_EN
  ,
  output logic [CSIZE-1:0] pop_cnt
`endif
);
  typedef enum logic [1:0] {S0 = 2'd0, S1 = 2'd1, S2 = 2'd2} state_t;
  state_t state_q, state_d;
  logic [DSIZE-1:0] head_q, head_d, skid_q, skid_d;
  logic acc;
  assign rinc    = ~rrst & ~rempty & ~halt & ~flush & (state_q != S2);
  assign m_valid = state_q != S0;
  assign m_data  = head_q;
  assign occ     = state_q;
  assign acc     = m_valid & m_ready;
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (flush) state_d = S0;
    else
      case (state_q)
        S0: if (rinc) begin
          state_d = S1;
          head_d  = rdata;
        end
        S1: if (rinc && acc) head_d = rdata;
        else if (rinc) begin
          state_d = S2;
          skid_d  = rdata;
        end
        else if (acc) state_d = S0;
        default: if (acc) begin
          state_d = S1;
          head_d  = skid_q;
        end
      endcase
  end
  always_ff @(posedge rclk) begin
    if (rrst) begin
      state_q <= S0;
      head_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
    end
  end
`ifdef FRS_CNT_EN
  logic [CSIZE-1:0] cnt_q, cnt_d;
  assign cnt_d   = cnt_q + CSIZE'(rinc);
  assign pop_cnt = cnt_q;
  always_ff @(posedge rclk) cnt_q <= rrst ? '0 : cnt_d;
`endif
endmodule
